uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter: the next generation of the fixed-format byte transmitter. It serialises one character per frame on `txd` with a start bit, DATA_BITS data bits sent LSB first, an optional parity bit and 1 or 2 stop bits. A one-entry holding register gives a valid/ready handshake toward the core, so back-to-back frames go out with no idle gap. It sits between the core-side I/O register and the `txd` pin.

## Interface
- DATA_BITS, 8: character width; legal 5..9.
- CLKS_PER_BIT, 16: clk cycles per bit period; legal ≥2.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd parity.
- STOP_BITS, 1: number of stop bits; legal 1 or 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  character to send; sampled on handshake.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty; equal to !hold_valid, driven from a register.
- txd  out  1  serial line; idles high; registered.
- busy  out  1  high while the FSM is in any state other than IDLE.
- done  out  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- Handshake:
  - Data is accepted on a rising edge where tx_valid && tx_ready; tx_data is latched into hold and hold_valid is set.
  - tx_valid held high while tx_ready is low is ignored, with no side effects.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If hold_valid, the next edge loads the shift register from hold, clears hold_valid and enters START.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txd = shift[0]. Every CLKS_PER_BIT cycles the register shifts right and bit_cnt increments. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: txd = ^data XOR PARITY_ODD, using the original character, for one bit period. Then STOP.
  - STOP: txd=1 for STOP_BITS×CLKS_PER_BIT cycles. In the final cycle done=1. The next edge enters START if hold_valid (loading from hold as IDLE does), else IDLE.
- Counters:
  - baud_cnt: $clog2(CLKS_PER_BIT) bits. Counts 0..CLKS_PER_BIT-1, clears at each bit boundary and on a state change, and holds at 0 in IDLE.
  - bit_cnt: $clog2(DATA_BITS+1) bits, cleared on entry to DATA.
  - stop_cnt: 1 bit.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, exactly.
- Hold buffer: while a frame is in flight, hold accepts the next character. tx_ready returns high on the edge that moves hold into the shift register.
- Reset asserted (reset=0) at any time, including mid-frame:
  - state=IDLE, txd=1, hold_valid=0, all counters 0, done=0, busy=0.
  - A partial frame is abandoned with no completion pulse.

## Timing
- Reset values: txd=1, tx_ready=1, busy=0, done=0.
- Let cycle C be the cycle whose closing edge accepts data while the FSM is IDLE:
  - hold_valid=1 and tx_ready=0 in C+1.
  - The start bit (txd=0) and busy=1 begin in C+2.
  - tx_ready returns to 1 in C+2.
- Back-to-back: if hold_valid=1 at the end of the last stop cycle, the next start bit begins in the following cycle (0 idle cycles) and busy stays 1.
- done is 1 for exactly one cycle per frame, coincident with the last txd=1 stop cycle. busy falls on the next edge unless a new frame follows.
- The data character is frozen in the shift register at load; changes on tx_data after acceptance have no effect on the frame.

## Test plan
- Reset: hold reset=0 mid-frame, after 3 cycles of the START state → txd=1, busy=0, tx_ready=1 asynchronously. After release, 100 cycles with tx_valid=0 → txd stays 1 and done never pulses.
- Basic 8N1 (DATA_BITS=8, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1): send 0xA5 → txd low cycles C+2..C+5, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high. done fires at C+41 and busy is high for 40 cycles.
- Parity, DATA_BITS=8: send 0x07.
  - PARITY_EN=1, PARITY_ODD=0 → parity bit 1.
  - PARITY_ODD=1 → parity bit 0.
  - Frame is 11×CLKS_PER_BIT cycles in both cases.
- Back-to-back with STOP_BITS=2: offer 0x55 then 0xAA, with tx_valid high continuously.
  - 0xAA is accepted while 0x55 is in flight.
  - Start of frame 2 immediately follows the 2nd stop bit of frame 1.
  - tx_ready is low from the 2nd acceptance until frame-2 load.
  - done pulses twice.
- Backpressure: drive tx_valid=1 with a changing tx_data while tx_ready=0 → only characters sampled when tx_ready=1 appear on txd, in acceptance order.
- Width corners: DATA_BITS=5, send 0x1F → 5 data ones. DATA_BITS=9, send 0x100 → eight 0s then a 1, with the frame length formula satisfied.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// ---------------------------------------------------------------------------
// uart_tx_param_if
// Character handshake between the core-side I/O register and the UART
// transmitter.
//   tx_data  : character to send, sampled when tx_valid && tx_ready
//   tx_valid : tx_data holds a character to send
//   tx_ready : transmitter holding register is empty
// master = core side (drives data/valid), slave = transmitter (drives ready).
// ---------------------------------------------------------------------------
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter. Each frame is a start bit, DATA_BITS data
// bits LSB first, an optional parity bit and 1 or 2 stop bits, each bit
// lasting CLKS_PER_BIT clocks. A one-entry holding register behind a
// valid/ready handshake lets the next character be queued while a frame is
// on the line, so consecutive frames leave with no idle gap.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   tx_if  : slave side of the character handshake (tx_data/tx_valid/tx_ready)
//   txd    : registered serial line, idles high
//   busy   : FSM is outside IDLE
//   done   : one-cycle pulse in the last cycle of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_param_if.slave tx_if,
  output logic           txd,
  output logic           busy,
  output logic           done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 hold_vld_q, hold_vld_d;
  logic                 ready_q;
  logic                 txd_q, txd_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;

  logic bit_end;
  logic last_stop;
  logic accept;
  logic load;

  // Parity of the whole character, inverted for odd parity.
  function automatic logic char_parity(input logic [DATA_BITS-1:0] c);
    return (^c) ^ PAR_ODD;
  endfunction

  assign bit_end   = (baud_q == BAUD_LAST);
  assign last_stop = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);
  // ready_q mirrors !hold_vld_q, so accept and load can never coincide.
  assign accept    = tx_if.tx_valid && ready_q;
  assign load      = hold_vld_q && ((state_q == IDLE) || last_stop);

  // State register: control state is reset, character data is not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      hold_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      hold_vld_q <= hold_vld_d;
      ready_q    <= !hold_vld_d;
      txd_q      <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  // Next-state logic: FSM, bit timing counters and holding register.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    par_d      = par_q;

    if (accept) begin
      hold_d     = tx_if.tx_data;
      hold_vld_d = 1'b1;
    end

    // Parity is taken from the character at load, before any shifting.
    if (load) begin
      shift_d    = hold_q;
      par_d      = char_parity(hold_q);
      hold_vld_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (hold_vld_q) state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            stop_d  = 1'b0;
            state_d = HAS_PAR ? PARITY : STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          stop_d  = 1'b0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            state_d = hold_vld_q ? START : IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: txd is decoded from the next state so the registered line
  // changes on the same edge as the FSM.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_d;
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  assign tx_if.tx_ready = ready_q;
  assign txd            = txd_q;
  assign busy           = (state_q != IDLE);
  assign done           = last_stop;

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
// Bench for uart_tx_param. Six transmitters with different formats share one
// clock and reset. Characters are pushed to a per-transmitter queue when the
// handshake accepts them; a frame receiver pops the expected character when a
// start bit appears and checks every clock of the frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int N = 6;
  localparam int DB  [N] = '{8, 8, 8, 8, 5, 9};
  localparam int CPB [N] = '{4, 4, 4, 4, 3, 2};
  localparam int PE  [N] = '{0, 1, 1, 0, 0, 0};
  localparam int PO  [N] = '{0, 0, 1, 0, 0, 0};
  localparam int SB  [N] = '{1, 1, 1, 2, 1, 1};

  typedef struct {
    int         idx;
    logic [8:0] data;
    logic       par;
    int         len;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   valid_v;
  logic [N-1:0]   txd_v, rdy_v, busy_v, done_v;
  logic [8:0]     data_a [N];
  logic [8:0]     exp_q [N][$];
  int             done_cnt [N];
  int             cyc = 0;
  int             errors = 0;
  int             checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : gen_dut
    uart_tx_param_if #(.DATA_BITS(DB[g])) u_if ();
    logic txd_w, busy_w, done_w;

    assign u_if.tx_valid = valid_v[g];
    assign u_if.tx_data  = data_a[g][DB[g]-1:0];
    assign rdy_v[g]      = u_if.tx_ready;
    assign txd_v[g]      = txd_w;
    assign busy_v[g]     = busy_w;
    assign done_v[g]     = done_w;

    uart_tx_param #(
      .DATA_BITS   (DB[g]),
      .CLKS_PER_BIT(CPB[g]),
      .PARITY_EN   (PE[g]),
      .PARITY_ODD  (PO[g]),
      .STOP_BITS   (SB[g])
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .tx_if(u_if.slave),
      .txd  (txd_w),
      .busy (busy_w),
      .done (done_w)
    );
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_par(input logic [8:0] d, input int db, input int odd);
    logic p;
    p = (odd != 0);
    for (int i = 0; i < db; i++) p = p ^ d[i];
    return p;
  endfunction

  // Offer one character and hold tx_valid until it is accepted. Returns the
  // cycle whose closing edge accepts it; leaves the bench in the next cycle.
  task automatic send(input int idx, input logic [8:0] d, output int c);
    int n;
    n = 0;
    data_a[idx]  = d;
    valid_v[idx] = 1'b1;
    while (rdy_v[idx] !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tx_ready stayed 0x%0h, expected 0x1", rdy_v[idx]);
    end
    c = cyc;
    exp_q[idx].push_back(d);
    step();
    valid_v[idx] = 1'b0;
  endtask

  // Wait for a start bit, pop the expected character and check every cycle
  // of the frame: line level, busy, and done only in the very last cycle.
  task automatic rx_frame(input int idx, input string tag, output int start_cyc,
                          output int wait_n, output int done_cyc,
                          output logic [8:0] got, output logic got_par);
    logic [8:0] exp;
    logic       ep;
    logic       lvl;
    logic       last;
    int         slots, nb_bad, dn_bad, bz_bad;
    got = '0;
    got_par = 1'b0;
    start_cyc = -1;
    done_cyc = -1;
    wait_n = 0;
    while (txd_v[idx] !== 1'b0 && wait_n < 3000) begin
      step();
      wait_n++;
    end
    if (wait_n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_start: txd stayed 0x%0h, expected a 0x0 start bit", tag, txd_v[idx]);
      return;
    end
    if (exp_q[idx].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: frame seen with 0 characters queued, expected 1", tag);
      return;
    end
    exp = exp_q[idx].pop_front();
    ep = exp_par(exp, DB[idx], PO[idx]);
    start_cyc = cyc;
    slots = 1 + DB[idx] + PE[idx] + SB[idx];
    nb_bad = 0;
    dn_bad = 0;
    bz_bad = 0;
    for (int s = 0; s < slots; s++) begin
      if (s == 0)                               lvl = 1'b0;
      else if (s <= DB[idx])                    lvl = exp[s-1];
      else if (PE[idx] != 0 && s == DB[idx] + 1) lvl = ep;
      else                                      lvl = 1'b1;
      for (int c = 0; c < CPB[idx]; c++) begin
        if (c == 0 && s >= 1 && s <= DB[idx]) got[s-1] = txd_v[idx];
        if (c == 0 && PE[idx] != 0 && s == DB[idx] + 1) got_par = txd_v[idx];
        if (txd_v[idx] !== lvl) nb_bad++;
        last = (s == slots - 1) && (c == CPB[idx] - 1);
        if (done_v[idx] === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (done_v[idx] !== last) dn_bad++;
        if (busy_v[idx] !== 1'b1) bz_bad++;
        step();
      end
    end
    check({tag, "_bits_wrong"}, nb_bad, 0);
    check({tag, "_done_wrong"}, dn_bad, 0);
    check({tag, "_busy_low"}, bz_bad, 0);
  endtask

  initial begin
    vec_t       tbl [10];
    int         c, c1, c2, s, s2, w, dc, rise, bad, d0;
    logic [8:0] got;
    logic       gp;

    tbl[0] = '{0, 9'h000, 1'b0, 40};
    tbl[1] = '{0, 9'h0FF, 1'b0, 40};
    tbl[2] = '{1, 9'h007, 1'b1, 44};
    tbl[3] = '{2, 9'h007, 1'b0, 44};
    tbl[4] = '{1, 9'h000, 1'b0, 44};
    tbl[5] = '{2, 9'h000, 1'b1, 44};
    tbl[6] = '{4, 9'h01F, 1'b0, 21};
    tbl[7] = '{5, 9'h100, 1'b0, 22};
    tbl[8] = '{3, 9'h03C, 1'b0, 44};
    tbl[9] = '{4, 9'h00A, 1'b0, 21};

    c1 = 0; c2 = 0; rise = 0; s2 = 0;
    valid_v = '0;
    for (int i = 0; i < N; i++) data_a[i] = '0;

    // Reset values
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_txd%0d", i), 32'(txd_v[i]), 1);
      check($sformatf("rst_rdy%0d", i), 32'(rdy_v[i]), 1);
      check($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 0);
      check($sformatf("rst_done%0d", i), 32'(done_v[i]), 0);
    end
    step();
    step();
    #3 reset = 1'b1;
    step();

    // Basic 8N1 frame with exact handshake and frame timing
    send(0, 9'h0A5, c);
    check("basic_rdy_c1", 32'(rdy_v[0]), 0);
    check("basic_txd_c1", 32'(txd_v[0]), 1);
    check("basic_busy_c1", 32'(busy_v[0]), 0);
    data_a[0] = 9'h05A;
    step();
    check("basic_txd_c2", 32'(txd_v[0]), 0);
    check("basic_busy_c2", 32'(busy_v[0]), 1);
    check("basic_rdy_c2", 32'(rdy_v[0]), 1);
    rx_frame(0, "basic", s, w, dc, got, gp);
    check("basic_start_cyc", s, c + 2);
    check("basic_done_cyc", dc, c + 41);
    check("basic_data", 32'(got), 32'h0A5);
    check("basic_busy_after", 32'(busy_v[0]), 0);
    check("basic_txd_after", 32'(txd_v[0]), 1);
    step();

    // Format table: parity, widths, stop bits
    for (int t = 0; t < 10; t++) begin
      send(tbl[t].idx, tbl[t].data, c);
      rx_frame(tbl[t].idx, $sformatf("vec%0d", t), s, w, dc, got, gp);
      check($sformatf("vec%0d_len", t), dc - s + 1, tbl[t].len);
      check($sformatf("vec%0d_data", t), 32'(got), 32'(tbl[t].data));
      if (PE[tbl[t].idx] != 0)
        check($sformatf("vec%0d_par", t), 32'(gp), 32'(tbl[t].par));
      check($sformatf("vec%0d_idle", t), 32'(busy_v[tbl[t].idx]), 0);
      step();
      step();
    end

    // Back-to-back with two stop bits and tx_valid held high
    d0 = done_cnt[3];
    fork
      begin
        int n1;
        data_a[3]  = 9'h055;
        valid_v[3] = 1'b1;
        n1 = 0;
        while (rdy_v[3] !== 1'b1 && n1 < 100) begin step(); n1++; end
        c1 = cyc;
        exp_q[3].push_back(9'h055);
        step();
        data_a[3] = 9'h0AA;
        n1 = 0;
        while (rdy_v[3] !== 1'b1 && n1 < 100) begin step(); n1++; end
        c2 = cyc;
        exp_q[3].push_back(9'h0AA);
        step();
        valid_v[3] = 1'b0;
        n1 = 0;
        while (rdy_v[3] !== 1'b1 && n1 < 200) begin step(); n1++; end
        rise = cyc;
      end
      begin
        int w2;
        logic [8:0] g1;
        logic p1;
        int s1, dc1;
        rx_frame(3, "b2b_f1", s1, w2, dc1, g1, p1);
        check("b2b_f1_data", 32'(g1), 32'h055);
        rx_frame(3, "b2b_f2", s2, w2, dc1, g1, p1);
        check("b2b_gap", w2, 0);
        check("b2b_f2_data", 32'(g1), 32'h0AA);
      end
    join
    check("b2b_second_accept", c2, c1 + 2);
    check("b2b_ready_rise", rise, s2);
    check("b2b_done_pulses", done_cnt[3] - d0, 2);
    step();

    // Backpressure: data changes every cycle, only accepted characters go out
    fork
      begin
        int k, acc, n2;
        k = 0; acc = 0; n2 = 0;
        valid_v[0] = 1'b1;
        while (acc < 3 && n2 < 2000) begin
          data_a[0] = {1'b0, 8'(8'h30 + k)};
          k++;
          if (rdy_v[0] === 1'b1) begin
            exp_q[0].push_back(data_a[0]);
            acc++;
          end
          step();
          n2++;
        end
        valid_v[0] = 1'b0;
      end
      begin
        int sb, wb, db;
        logic [8:0] gb;
        logic pb;
        for (int f = 0; f < 3; f++) rx_frame(0, $sformatf("bp%0d", f), sb, wb, db, gb, pb);
      end
    join
    check("bp_queue_left", exp_q[0].size(), 0);
    step();

    // Reset in the middle of a frame, three cycles into START
    send(0, 9'h03C, c);
    step();
    step();
    step();
    check("mid_pre_txd", 32'(txd_v[0]), 0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_txd", 32'(txd_v[0]), 1);
    check("mid_rst_busy", 32'(busy_v[0]), 0);
    check("mid_rst_rdy", 32'(rdy_v[0]), 1);
    check("mid_rst_done", 32'(done_v[0]), 0);
    exp_q[0].delete();
    step();
    step();
    #3 reset = 1'b1;
    d0 = done_cnt[0];
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (txd_v[0] !== 1'b1) bad++;
    end
    check("post_rst_txd_low", bad, 0);
    check("post_rst_done", done_cnt[0] - d0, 0);
    check("post_rst_busy", 32'(busy_v[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
